// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic processing element family.
package systolic_pkg;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } pe_mode_e;

    typedef enum logic [1:0] {
        OS_RUN     = 2'd0,
        OS_CAPTURE = 2'd1,
        OS_SHIFT   = 2'd2
    } os_state_e;

    // Largest positive value of a w-bit two's-complement number (w <= 64).
    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit two's-complement number (w <= 64).
    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/systolic_sat_add.sv
// Combinational signed adder with optional clamp on overflow.
module systolic_sat_add
    import systolic_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int SAT_EN = 1
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] w_full;

    // One guard bit: guard disagreeing with the result MSB means the true sum left the range
    always_comb begin
        w_full = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
        o_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];
        if (o_ovf && (SAT_EN != 0))
            o_sum = w_full[ACC_W] ? MIN_V : MAX_V;
        else
            o_sum = w_full[ACC_W-1:0];
    end

endmodule

// File: rtl/systolic_pe_mm.sv
// Dual-mode systolic PE: weight-stationary MAC with double-buffered weight,
// or output-stationary accumulator that drains down the partial-sum chain.
//
// OS state   | meaning
// OS_RUN     | accumulating; first drain_in cycle captures acc onto ps_out
// OS_CAPTURE | acc was captured last cycle; drain_in continues into shifting
// OS_SHIFT   | forwarding ps_in (upstream drain data) onto ps_out
module systolic_pe_mm
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [ACC_W-1:0]  ps_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_shift,
    input  logic              w_swap,
    input  logic              acc_clr,
    input  logic              drain_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  ps_out,
    output logic [DATA_W-1:0] w_out,
    output logic              drain_out,
    output logic              ovf
);

    if (ACC_W < 2*DATA_W + 1) begin : g_bad_acc_w
        $error("systolic_pe_mm: ACC_W must be at least 2*DATA_W+1");
    end

    pe_mode_e          w_mode;
    logic              w_mode_chg;
    logic [DATA_W-1:0] w_op;
    logic [2*DATA_W-1:0] w_a_ext, w_op_ext, w_prod;
    logic [ACC_W-1:0]  w_p_ext;
    logic [ACC_W-1:0]  w_add_in;
    logic [ACC_W-1:0]  w_sum;
    logic              w_sum_ovf;

    logic              r_mode_q;
    os_state_e         r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_ps_out;
    logic [DATA_W-1:0] r_w_sh, r_w_act;
    logic [DATA_W-1:0] r_a_out, r_b_out;
    logic              r_valid_out, r_drain_out, r_ovf;

    // Operand select and sign-extended product; one adder shared between ps_in and acc
    always_comb begin
        w_mode     = pe_mode_e'(mode_i);
        w_mode_chg = mode_i ^ r_mode_q;
        w_op       = (w_mode == MODE_OS) ? b_in : r_w_act;
        w_a_ext    = {{DATA_W{a_in[DATA_W-1]}}, a_in};
        w_op_ext   = {{DATA_W{w_op[DATA_W-1]}}, w_op};
        w_prod     = w_a_ext * w_op_ext;
        w_p_ext    = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
        w_add_in   = (w_mode == MODE_OS) ? r_acc : ps_in;
    end

    systolic_sat_add #(
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .i_a   (w_add_in),
        .i_b   (w_p_ext),
        .o_sum (w_sum),
        .o_ovf (w_sum_ovf)
    );

    // Datapath, weight chain and OS drain FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q    <= 1'b0;
            r_state     <= OS_RUN;
            r_acc       <= '0;
            r_ps_out    <= '0;
            r_w_sh      <= '0;
            r_w_act     <= '0;
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_valid_out <= 1'b0;
            r_drain_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_mode_q    <= mode_i;
            r_valid_out <= valid_in & ~drain_in;
            if (valid_in && !drain_in) begin
                r_a_out <= a_in;
                r_b_out <= b_in;
            end
            if (w_shift) r_w_sh  <= w_in;
            if (w_swap)  r_w_act <= r_w_sh;

            if (w_mode_chg) begin
                r_acc       <= '0;
                r_ovf       <= 1'b0;
                r_state     <= OS_RUN;
                r_drain_out <= 1'b0;
            end else if (w_mode == MODE_WS) begin
                r_state     <= OS_RUN;
                r_drain_out <= 1'b0;
                if (valid_in) begin
                    r_ps_out <= w_sum;
                    if (w_sum_ovf) r_ovf <= 1'b1;
                end
            end else begin
                case (r_state)
                    OS_RUN: begin
                        if (drain_in) begin
                            r_ps_out    <= r_acc;
                            r_acc       <= '0;
                            r_drain_out <= 1'b1;
                            r_state     <= OS_CAPTURE;
                        end else if (acc_clr) begin
                            r_acc <= valid_in ? w_p_ext : '0;
                            r_ovf <= 1'b0;
                        end else if (valid_in) begin
                            r_acc <= w_sum;
                            if (w_sum_ovf) r_ovf <= 1'b1;
                        end
                    end
                    default: begin
                        if (drain_in) begin
                            r_ps_out    <= ps_in;
                            r_drain_out <= 1'b1;
                            r_state     <= OS_SHIFT;
                        end else begin
                            r_drain_out <= 1'b0;
                            r_state     <= OS_RUN;
                        end
                    end
                endcase
            end
        end
    end

    assign valid_out = r_valid_out;
    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign ps_out    = r_ps_out;
    assign w_out     = r_w_sh;
    assign drain_out = r_drain_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_systolic_pe_mm.sv
// Bench for systolic_pe_mm: one 32-bit accumulator instance plus two 17-bit
// instances (clamping and wrapping) sharing the same control stimulus.
module tb_systolic_pe_mm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_i = 1'b0, valid_in = 1'b0, w_shift = 1'b0, w_swap = 1'b0;
    logic        acc_clr = 1'b0, drain_in = 1'b0;
    logic [7:0]  a_in = '0, b_in = '0, w_in = '0;
    logic [31:0] ps32 = '0;
    logic [16:0] ps17 = '0;

    logic        vo0, vo1, vo2, do0, do1, do2, ovf0, ovf1, ovf2;
    logic [7:0]  ao0, ao1, ao2, bo0, bo1, bo2, wo0, wo1, wo2;
    logic [31:0] pso0;
    logic [16:0] pso1, pso2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_pe_mm #(.DATA_W(8), .ACC_W(32), .SAT_EN(1)) dut_acc32 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .ps_in(ps32), .w_in(w_in), .w_shift(w_shift),
        .w_swap(w_swap), .acc_clr(acc_clr), .drain_in(drain_in),
        .valid_out(vo0), .a_out(ao0), .b_out(bo0), .ps_out(pso0), .w_out(wo0),
        .drain_out(do0), .ovf(ovf0));

    systolic_pe_mm #(.DATA_W(8), .ACC_W(17), .SAT_EN(1)) dut_sat17 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .ps_in(ps17), .w_in(w_in), .w_shift(w_shift),
        .w_swap(w_swap), .acc_clr(acc_clr), .drain_in(drain_in),
        .valid_out(vo1), .a_out(ao1), .b_out(bo1), .ps_out(pso1), .w_out(wo1),
        .drain_out(do1), .ovf(ovf1));

    systolic_pe_mm #(.DATA_W(8), .ACC_W(17), .SAT_EN(0)) dut_wrap17 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .ps_in(ps17), .w_in(w_in), .w_shift(w_shift),
        .w_swap(w_swap), .acc_clr(acc_clr), .drain_in(drain_in),
        .valid_out(vo2), .a_out(ao2), .b_out(bo2), .ps_out(pso2), .w_out(wo2),
        .drain_out(do2), .ovf(ovf2));

    // Reference model state (signed integers, one accumulator per instance)
    int     ACCW [3] = '{32, 17, 17};
    bit     SATEN[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3], m_ps[3];
    bit     m_ovf[3];
    longint m_w_sh, m_w_act, m_a_out, m_b_out;
    bit     m_valid_out, m_drain_out, m_in_drain, m_mode_q;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_to(input longint x, input int w);
        longint m, r;
        m = longint'(1) <<< w;
        r = ((x % m) + m) % m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint sat(input longint x, input int w, input bit en,
                                   output bit o);
        longint lo, hi;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        o  = (x < lo) || (x > hi);
        if (!o)     return x;
        else if (en) return (x < lo) ? lo : hi;
        else        return wrap_to(x, w);
    endfunction

    function automatic longint ps_val(input int k);
        return (k == 0) ? longint'($signed(ps32)) : longint'($signed(ps17));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_ps[k] = 0; m_ovf[k] = 1'b0;
        end
        m_w_sh = 0; m_w_act = 0; m_a_out = 0; m_b_out = 0;
        m_valid_out = 1'b0; m_drain_out = 1'b0; m_in_drain = 1'b0; m_mode_q = 1'b0;
    endfunction

    // Predicts the registered outputs after the coming clock edge
    function automatic void model_update();
        bit     chg, o;
        longint a, b, p;
        chg = (mode_i != m_mode_q);
        a   = longint'($signed(a_in));
        b   = longint'($signed(b_in));
        p   = mode_i ? a * b : a * m_w_act;
        for (int k = 0; k < 3; k++) begin
            if (chg) begin
                m_acc[k] = 0; m_ovf[k] = 1'b0;
            end else if (!mode_i) begin
                if (valid_in) begin
                    m_ps[k] = sat(ps_val(k) + p, ACCW[k], SATEN[k], o);
                    if (o) m_ovf[k] = 1'b1;
                end
            end else if (!m_in_drain) begin
                if (drain_in) begin
                    m_ps[k] = m_acc[k]; m_acc[k] = 0;
                end else if (acc_clr) begin
                    m_acc[k] = valid_in ? p : 0; m_ovf[k] = 1'b0;
                end else if (valid_in) begin
                    m_acc[k] = sat(m_acc[k] + p, ACCW[k], SATEN[k], o);
                    if (o) m_ovf[k] = 1'b1;
                end
            end else if (drain_in) begin
                m_ps[k] = ps_val(k);
            end
        end
        if (chg || !mode_i) begin
            m_drain_out = 1'b0; m_in_drain = 1'b0;
        end else if (!m_in_drain) begin
            if (drain_in) begin m_drain_out = 1'b1; m_in_drain = 1'b1; end
        end else begin
            m_drain_out = drain_in; m_in_drain = drain_in;
        end
        m_valid_out = valid_in && !drain_in;
        if (valid_in && !drain_in) begin m_a_out = a; m_b_out = b; end
        if (w_swap)  m_w_act = m_w_sh;
        if (w_shift) m_w_sh  = longint'($signed(w_in));
        m_mode_q = mode_i;
    endfunction

    task automatic check_all();
        chk("valid_out", vo0, m_valid_out);
        chk("a_out", $signed(ao0), m_a_out);
        chk("b_out", $signed(bo0), m_b_out);
        chk("w_out", $signed(wo0), m_w_sh);
        chk("drain_out", do0, m_drain_out);
        chk("ps_out_acc32", $signed(pso0), m_ps[0]);
        chk("ps_out_sat17", $signed(pso1), m_ps[1]);
        chk("ps_out_wrap17", $signed(pso2), m_ps[2]);
        chk("ovf_acc32", ovf0, m_ovf[0]);
        chk("ovf_sat17", ovf1, m_ovf[1]);
        chk("ovf_wrap17", ovf2, m_ovf[2]);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_valid_out"}, vo0, 0);
        chk({tag, "_a_out"}, ao0, 0);
        chk({tag, "_b_out"}, bo0, 0);
        chk({tag, "_ps_out"}, pso0, 0);
        chk({tag, "_w_out"}, wo0, 0);
        chk({tag, "_drain_out"}, do0, 0);
        chk({tag, "_ovf"}, ovf0, 0);
        chk({tag, "_ps_out17"}, pso1, 0);
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("reset");
        rst_n = 1'b1;

        // WS basic: load 5, swap, 3*5 + 10
        w_in = 8'd5; w_shift = 1'b1; step();
        w_shift = 1'b0; w_swap = 1'b1; step();
        w_swap = 1'b0; valid_in = 1'b1; a_in = 8'd3; ps32 = 32'd10; step();
        chk("ws_basic_ps", $signed(pso0), 25);
        chk("ws_basic_valid", vo0, 1);
        chk("ws_basic_a_out", ao0, 3);

        // Double buffer: shadow loads 7 while 5 stays active
        w_in = 8'd7; w_shift = 1'b1; a_in = 8'd2; ps32 = 32'd0; step();
        chk("dbuf_ps_before_swap", $signed(pso0), 10);
        w_shift = 1'b0; step();
        chk("dbuf_ps_hold_w", $signed(pso0), 10);
        valid_in = 1'b0; w_swap = 1'b1; w_shift = 1'b1; w_in = 8'd9; step();
        chk("dbuf_swap_shift_w_out", wo0, 9);
        w_swap = 1'b0; w_shift = 1'b0; valid_in = 1'b1; a_in = 8'd2; step();
        chk("dbuf_ps_after_swap", $signed(pso0), 14);

        // OS accumulate and two-cycle drain
        valid_in = 1'b0; mode_i = 1'b1; step();
        valid_in = 1'b1; a_in = 8'd2; b_in = 8'd3; step();
        a_in = 8'd4; b_in = 8'hFF; step();
        a_in = 8'hFB; b_in = 8'hFB; step();
        valid_in = 1'b0; drain_in = 1'b1; ps32 = 32'd99; step();
        chk("os_drain_capture", $signed(pso0), 27);
        chk("os_drain_out_1", do0, 1);
        step();
        chk("os_drain_shift", $signed(pso0), 99);
        chk("os_drain_out_2", do0, 1);
        drain_in = 1'b0; step();
        chk("os_drain_out_end", do0, 0);
        drain_in = 1'b1; step();
        chk("os_acc_zero_after_drain", $signed(pso0), 0);
        drain_in = 1'b0; step();

        // 17-bit overflow in OS, then acc_clr clears ovf and reloads
        valid_in = 1'b1; a_in = 8'd127; b_in = 8'd127;
        repeat (5) step();
        chk("os_sat17_ovf", ovf1, 1);
        chk("os_wrap17_ovf", ovf2, 1);
        valid_in = 1'b0; acc_clr = 1'b1; step();
        chk("acc_clr_ovf", ovf1, 0);
        acc_clr = 1'b0; valid_in = 1'b1; a_in = 8'd5; b_in = 8'd10; step();
        acc_clr = 1'b1; a_in = 8'd3; b_in = 8'd4; step();
        chk("acc_clr_valid_ovf", ovf1, 0);
        acc_clr = 1'b0; valid_in = 1'b0; drain_in = 1'b1; step();
        chk("acc_clr_valid_acc", $signed(pso0), 12);
        drain_in = 1'b0; step();

        // Mode toggle clears the accumulator
        valid_in = 1'b1; a_in = 8'd3; b_in = 8'd4; step();
        valid_in = 1'b0; mode_i = 1'b0; step();
        mode_i = 1'b1; step();
        drain_in = 1'b1; step();
        chk("mode_toggle_acc", $signed(pso0), 0);
        drain_in = 1'b0; step();

        // WS saturation / wrap at 17 bits
        mode_i = 1'b0; step();
        w_in = 8'd127; w_shift = 1'b1; step();
        w_shift = 1'b0; w_swap = 1'b1; step();
        w_swap = 1'b0; valid_in = 1'b1; a_in = 8'd127; ps17 = 17'd65000; ps32 = 32'd65000;
        step();
        chk("ws_sat17_ps", $signed(pso1), 65535);
        chk("ws_sat17_ovf", ovf1, 1);
        chk("ws_wrap17_ps", $signed(pso2), -49943);
        chk("ws_wrap17_ovf", ovf2, 1);
        chk("ws_acc32_ps", $signed(pso0), 81129);
        valid_in = 1'b0;

        // Reset in the middle of a drain shift
        mode_i = 1'b1; step();
        valid_in = 1'b1; a_in = 8'd6; b_in = 8'd7; step();
        valid_in = 1'b0; drain_in = 1'b1; ps32 = 32'd5; step();
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_zero("mid_shift_reset");
        model_reset();
        drain_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        drain_in = 1'b1; step();
        chk("post_reset_drain", $signed(pso0), 0);
        drain_in = 1'b0; step();

        // Randomized mixed traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) mode_i = ~mode_i;
            valid_in = ($urandom_range(0, 9) < 7);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            w_in     = 8'($urandom);
            w_shift  = ($urandom_range(0, 4) == 0);
            w_swap   = ($urandom_range(0, 5) == 0);
            acc_clr  = ($urandom_range(0, 9) == 0);
            if (drain_in) drain_in = ($urandom_range(0, 2) != 0);
            else          drain_in = ($urandom_range(0, 15) == 0);
            ps32 = $urandom;
            ps17 = 17'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
